pixel_compositor: RTL and testbench
===================================

PIXEL_COMPOSITOR -- requirements
Module: pixel_compositor

Interface
REQ-001 SHALL have parameter H_LAST, default 10'd799, meaning the last hCount value of a line.
REQ-002 SHALL have parameter V_LAST, default 10'd524, meaning the last vCount value of a frame.
REQ-003 SHALL have parameter DOTCOLOR, default 12'hFFF, meaning the pellet pixel colour.
REQ-004 SHALL have parameter BGCOLOR, default 12'h000, meaning the background colour.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have ports hCount and vCount, input, 10 bits each: current scan position from the VGA timing generator.
REQ-008 SHALL have port bright, input, 1 bit: visible-region flag.
REQ-009 SHALL have ports wallRgb, pacRgb and ghostRgb, input, 12 bits each: per-layer colours.
REQ-010 SHALL have ports wallFill, pacFill, ghostFill and dotFill, input, 1 bit each: per-layer coverage of the current pixel.
REQ-011 SHALL have port clearHits, input, 1 bit: synchronous clear of ghostHits.
REQ-012 SHALL have port rgb, output, 12 bits: registered pixel colour to the DAC.
REQ-013 SHALL have port collWall, output, 1 bit: set when pacman overlapped a wall in the last completed frame.
REQ-014 SHALL have port collGhost, output, 1 bit: set when pacman overlapped a ghost in the last completed frame.
REQ-015 SHALL have port dotEaten, output, 1 bit: set when pacman overlapped a dot in the last completed frame.
REQ-016 SHALL have port frameDone, output, 1 bit: one-cycle pulse when the status outputs update.
REQ-017 SHALL have port ghostHits, output, 8 bits: saturating count of frames with ghost collision.

Function
REQ-018 SHALL register all layer inputs, bright and hCount/vCount in stage 1 on every clock edge.
REQ-019 SHALL select a colour from the stage-1 registers and register it into rgb in stage 2, giving an input-to-rgb latency of exactly 2 clocks.
REQ-020 SHALL use colour priority: stage-1 bright=0 gives BGCOLOR, then ghostFill gives ghostRgb, then pacFill gives pacRgb, then wallFill gives wallRgb, then dotFill gives DOTCOLOR, else BGCOLOR.
REQ-021 SHALL evaluate pixel collisions from stage-1 registers only while stage-1 bright=1: cw = pac&wall, cg = pac&ghost, cd = pac&dot.
REQ-022 SHALL OR cw/cg/cd into three in-frame accumulators every cycle.
REQ-023 SHALL define the frame-end cycle as stage-1 hCount==H_LAST and vCount==V_LAST.
REQ-024 SHALL, on the edge after a frame-end cycle, load collWall/collGhost/dotEaten with accumulator OR that cycle's cw/cg/cd, clear the accumulators to 0, and set frameDone=1 for exactly one cycle.
REQ-025 SHALL hold the status outputs constant between frame-end updates.
REQ-026 SHALL increment ghostHits by 1 at each frame-end update whose loaded collGhost value is 1, saturating at 8'hFF with no wrap.
REQ-027 SHALL clear ghostHits to 0 on any clock edge where clearHits=1; if clearHits coincides with an increment, the result SHALL be 0.
REQ-028 SHALL let stage-1 collisions accumulate into the new frame on the cycle after a frame end; no pixel is lost or double-counted.
REQ-029 SHALL never assert frameDone on two consecutive cycles.
REQ-030 SHALL take coordinates beyond H_LAST/V_LAST as non-frame-end, with no other effect.

Reset
REQ-031 SHALL, while rst_n=0 (asynchronously), hold rgb=12'h000, all pipeline registers=0, accumulators=0, collWall/collGhost/dotEaten=0, frameDone=0 and ghostHits=0.
REQ-032 SHALL, when rst_n is asserted mid-frame, discard that frame's accumulated collisions; the first frameDone after release SHALL reflect only post-reset pixels.
REQ-033 SHALL produce no frameDone pulse from reset release itself.

Verification
REQ-034 SHALL be covered by a priority test: bright=1, ghostFill=pacFill=wallFill=1, ghostRgb=12'hF00 -> rgb=12'hF00 two clocks later; dropping ghostFill -> pacRgb; bright=0 -> 12'h000.
REQ-035 SHALL be covered by a wall-collision test: pacFill=wallFill=1 for one visible pixel mid-frame -> at frame end collWall=1, frameDone one cycle, collGhost=0; next clean frame -> collWall=0.
REQ-036 SHALL be covered by a boundary test: collision only on the pixel at (H_LAST,V_LAST) with bright forced 1 -> counted in the ending frame, not the next.
REQ-037 SHALL be covered by a saturation test: ghost collision in 260 consecutive frames -> ghostHits=255; clearHits pulse on a frame-end increment -> ghostHits=0.
REQ-038 SHALL be covered by a reset test: rst_n low mid-frame after a ghost collision, released -> clean remainder of frame gives collGhost=0, ghostHits=0.
REQ-039 SHALL be covered by a blanking test: pacFill=wallFill=1 with bright=0 for a whole frame -> collWall=0.

Source files
------------

// File: rtl/pixel_compositor.sv
`timescale 1ns/1ps
// pixel_compositor
// Two-stage pixel pipeline for a VGA sprite game. Stage 1 registers the scan
// position and every layer input; stage 2 picks the visible colour by layer
// priority and drives the DAC. In parallel, pacman overlaps with walls, ghosts
// and dots are OR-ed over the visible part of each frame and published as
// status flags at frame end, together with a saturating ghost-hit counter.

module pixel_compositor #(
    parameter logic [9:0]  H_LAST   = 10'd799,
    parameter logic [9:0]  V_LAST   = 10'd524,
    parameter logic [11:0] DOTCOLOR = 12'hFFF,
    parameter logic [11:0] BGCOLOR  = 12'h000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        bright,
    input  logic [11:0] wallRgb,
    input  logic [11:0] pacRgb,
    input  logic [11:0] ghostRgb,
    input  logic        wallFill,
    input  logic        pacFill,
    input  logic        ghostFill,
    input  logic        dotFill,
    input  logic        clearHits,
    output logic [11:0] rgb,
    output logic        collWall,
    output logic        collGhost,
    output logic        dotEaten,
    output logic        frameDone,
    output logic [7:0]  ghostHits
);

    // Everything the pipeline needs to know about one pixel.
    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        bright;
        logic [11:0] wall_rgb;
        logic [11:0] pac_rgb;
        logic [11:0] ghost_rgb;
        logic        wall;
        logic        pac;
        logic        ghost;
        logic        dot;
    } layer_t;

    // One flag per kind of pacman overlap.
    typedef struct packed {
        logic wall;
        logic ghost;
        logic dot;
    } coll_t;

    layer_t      s1_d;
    layer_t      s1_q;
    logic        s1_valid_q;

    logic [11:0] colour_d;
    logic [11:0] rgb_q;

    coll_t       hit;
    logic        frame_end;

    coll_t       acc_d;
    coll_t       acc_q;
    coll_t       status_d;
    coll_t       status_q;
    logic        frame_done_d;
    logic        frame_done_q;
    logic [7:0]  hits_d;
    logic [7:0]  hits_q;

    // Pack the raw per-pixel inputs into the stage-1 word.
    always_comb begin
        // NOTE: every always_comb output gets a full default first, so no path
        // through the block can leave it unassigned and infer a latch.
        s1_d           = '0;
        s1_d.h         = hCount;
        s1_d.v         = vCount;
        s1_d.bright    = bright;
        s1_d.wall_rgb  = wallRgb;
        s1_d.pac_rgb   = pacRgb;
        s1_d.ghost_rgb = ghostRgb;
        s1_d.wall      = wallFill;
        s1_d.pac       = pacFill;
        s1_d.ghost     = ghostFill;
        s1_d.dot       = dotFill;
    end

    // Stage 1: capture the pixel; valid marks that real input has been sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the data pipeline is reset too, so right after release the
            // colour and collision logic see a blank pixel instead of X.
            s1_q       <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every register sample the
            // pre-edge values, so stage order in the source does not matter.
            s1_q       <= s1_d;
            s1_valid_q <= 1'b1;
        end
    end

    // Layer priority: blanking, ghost, pacman, wall, dot, background.
    always_comb begin
        colour_d = BGCOLOR;
        if (!s1_q.bright) begin
            colour_d = BGCOLOR;
        end else if (s1_q.ghost) begin
            colour_d = s1_q.ghost_rgb;
        end else if (s1_q.pac) begin
            colour_d = s1_q.pac_rgb;
        end else if (s1_q.wall) begin
            colour_d = s1_q.wall_rgb;
        end else if (s1_q.dot) begin
            colour_d = DOTCOLOR;
        end
    end

    // Stage 2: registered colour to the DAC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q <= 12'h000;
        end else begin
            rgb_q <= colour_d;
        end
    end

    // Per-pixel overlaps (visible region only) and frame-end detection. A frame
    // end directly after another is ignored so frameDone never lasts two
    // cycles; that pixel then simply accumulates into the new frame.
    always_comb begin
        hit       = '0;
        hit.wall  = s1_q.bright & s1_q.pac & s1_q.wall;
        hit.ghost = s1_q.bright & s1_q.pac & s1_q.ghost;
        hit.dot   = s1_q.bright & s1_q.pac & s1_q.dot;
        frame_end = s1_valid_q && (s1_q.h == H_LAST) && (s1_q.v == V_LAST)
                    && !frame_done_q;
    end

    // Next-state for accumulators, published status, frame pulse and hit count.
    always_comb begin
        acc_d        = acc_q | hit;
        status_d     = status_q;
        frame_done_d = 1'b0;
        hits_d       = hits_q;
        if (frame_end) begin
            status_d     = acc_q | hit;
            acc_d        = '0;
            frame_done_d = 1'b1;
            if (status_d.ghost && (hits_q != 8'hFF)) begin
                hits_d = hits_q + 8'd1;
            end
        end
        // A clear always wins over a coincident increment.
        if (clearHits) begin
            hits_d = 8'h00;
        end
    end

    // Collision state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            status_q     <= '0;
            frame_done_q <= 1'b0;
            hits_q       <= 8'h00;
        end else begin
            acc_q        <= acc_d;
            status_q     <= status_d;
            frame_done_q <= frame_done_d;
            hits_q       <= hits_d;
        end
    end

    assign rgb       = rgb_q;
    assign collWall  = status_q.wall;
    assign collGhost = status_q.ghost;
    assign dotEaten  = status_q.dot;
    assign frameDone = frame_done_q;
    assign ghostHits = hits_q;

endmodule

// File: tb/tb_pixel_compositor.sv
`timescale 1ns/1ps
// Self-checking bench for pixel_compositor on a small 8x4 raster. A
// per-frame reference model predicts rgb and the status outputs after every
// clock; directed frames add explicit checks on priority, wall, corner,
// blanking, saturation and reset behaviour.

module tb_pixel_compositor;

    localparam logic [9:0]  TB_H  = 10'd7;
    localparam logic [9:0]  TB_V  = 10'd3;
    localparam logic [11:0] DOT_C = 12'hFFF;
    localparam logic [11:0] BG_C  = 12'h000;
    localparam int          LINE  = int'(TB_H) + 1;
    localparam int          PIX   = LINE * (int'(TB_V) + 1);

    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  hCount, vCount;
    logic        bright;
    logic [11:0] wallRgb, pacRgb, ghostRgb;
    logic        wallFill, pacFill, ghostFill, dotFill;
    logic        clearHits;
    logic [11:0] rgb;
    logic        collWall, collGhost, dotEaten, frameDone;
    logic [7:0]  ghostHits;

    always #5 clk = ~clk;

    pixel_compositor #(
        .H_LAST   (TB_H),
        .V_LAST   (TB_V),
        .DOTCOLOR (DOT_C),
        .BGCOLOR  (BG_C)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .hCount    (hCount),
        .vCount    (vCount),
        .bright    (bright),
        .wallRgb   (wallRgb),
        .pacRgb    (pacRgb),
        .ghostRgb  (ghostRgb),
        .wallFill  (wallFill),
        .pacFill   (pacFill),
        .ghostFill (ghostFill),
        .dotFill   (dotFill),
        .clearHits (clearHits),
        .rgb       (rgb),
        .collWall  (collWall),
        .collGhost (collGhost),
        .dotEaten  (dotEaten),
        .frameDone (frameDone),
        .ghostHits (ghostHits)
    );

    typedef struct packed {
        logic [9:0]  h;
        logic [9:0]  v;
        logic        bright;
        logic        wf, pf, gf, df;
        logic [11:0] wr, pr, gr;
    } pix_t;

    typedef enum int {M_CLEAN, M_RANDOM, M_WALL_ONE, M_GHOST_ONE, M_CORNER, M_BLANK, M_PRIO} mode_t;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    pix_t        m_prev;
    bit          m_have_prev;
    bit          m_acc_w, m_acc_g, m_acc_d;
    bit          m_st_w, m_st_g, m_st_d;
    bit          m_done;
    int          m_hits;
    logic [11:0] m_rgb;

    function automatic logic [11:0] ref_colour(input pix_t p);
        if (!p.bright) return BG_C;
        if (p.gf) return p.gr;
        if (p.pf) return p.pr;
        if (p.wf) return p.wr;
        if (p.df) return DOT_C;
        return BG_C;
    endfunction

    task automatic model_reset();
        m_prev      = '0;
        m_have_prev = 1'b0;
        m_acc_w = 0; m_acc_g = 0; m_acc_d = 0;
        m_st_w  = 0; m_st_g  = 0; m_st_d  = 0;
        m_done  = 0;
        m_hits  = 0;
        m_rgb   = 12'h000;
    endtask

    // One clock edge: the pixel applied one edge earlier becomes visible now.
    task automatic model_edge(input pix_t x, input bit clr);
        pix_t p;
        bit   cw, cg, cd, fend;
        p    = m_have_prev ? m_prev : '0;
        m_rgb = ref_colour(p);
        cw   = p.bright && p.pf && p.wf;
        cg   = p.bright && p.pf && p.gf;
        cd   = p.bright && p.pf && p.df;
        fend = m_have_prev && (p.h == TB_H) && (p.v == TB_V);
        m_done = fend;
        if (fend) begin
            m_st_w = m_acc_w || cw;
            m_st_g = m_acc_g || cg;
            m_st_d = m_acc_d || cd;
            m_acc_w = 0; m_acc_g = 0; m_acc_d = 0;
            if (m_st_g) m_hits = (m_hits >= 255) ? 255 : m_hits + 1;
        end else begin
            m_acc_w = m_acc_w || cw;
            m_acc_g = m_acc_g || cg;
            m_acc_d = m_acc_d || cd;
        end
        if (clr) m_hits = 0;
        m_prev      = x;
        m_have_prev = 1'b1;
    endtask

    function automatic logic [31:0] model_status();
        return {20'h0, m_st_w, m_st_g, m_st_d, m_done, 8'(m_hits)};
    endfunction

    function automatic logic [31:0] dut_status();
        return {20'h0, collWall, collGhost, dotEaten, frameDone, ghostHits};
    endfunction

    // ---------------- stimulus ----------------
    logic [11:0] obs_rgb  [PIX];
    logic        obs_cw   [PIX];
    logic        obs_cg   [PIX];
    logic        obs_cd   [PIX];
    logic        obs_fd   [PIX];
    logic [7:0]  obs_hits [PIX];

    task automatic apply(input pix_t x, input bit clr);
        hCount    = x.h;
        vCount    = x.v;
        bright    = x.bright;
        wallFill  = x.wf;
        pacFill   = x.pf;
        ghostFill = x.gf;
        dotFill   = x.df;
        wallRgb   = x.wr;
        pacRgb    = x.pr;
        ghostRgb  = x.gr;
        clearHits = clr;
        @(posedge clk);
        #1;
        model_edge(x, clr);
        check("rgb", 32'(rgb), 32'(m_rgb));
        check("status", dut_status(), model_status());
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("async_rst_rgb", 32'(rgb), 32'h0);
        check("async_rst_status", dut_status(), 32'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        check("held_rst_status", dut_status(), 32'h0);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic run_frame(input mode_t m, input bit clr_first = 1'b0, input int reset_at = -1);
        pix_t x;
        pix_t y;
        for (int idx = 0; idx < PIX; idx++) begin
            if (idx == reset_at) do_reset();
            x        = '0;
            x.h      = 10'(idx % LINE);
            x.v      = 10'(idx / LINE);
            x.bright = 1'b1;
            x.wr     = 12'h00F;
            x.pr     = 12'h0F0;
            x.gr     = 12'hF00;
            case (m)
                M_RANDOM: begin
                    x.bright = ($urandom_range(0, 3) != 0);
                    x.wf = ($urandom_range(0, 2) == 0);
                    x.pf = ($urandom_range(0, 2) == 0);
                    x.gf = ($urandom_range(0, 2) == 0);
                    x.df = ($urandom_range(0, 2) == 0);
                    x.wr = 12'($urandom);
                    x.pr = 12'($urandom);
                    x.gr = 12'($urandom);
                end
                M_WALL_ONE:  if (idx == PIX / 2 + 3) begin x.pf = 1; x.wf = 1; end
                M_GHOST_ONE: if (idx == 2) begin x.pf = 1; x.gf = 1; end
                M_CORNER:    if (idx == PIX - 1) begin x.pf = 1; x.df = 1; end
                M_BLANK:     begin x.bright = 0; x.pf = 1; x.wf = 1; end
                M_PRIO: begin
                    if (idx == 2) begin x.gf = 1; x.pf = 1; x.wf = 1; end
                    if (idx == 3) begin x.pf = 1; x.wf = 1; end
                    if (idx == 4) begin x.bright = 0; x.gf = 1; x.pf = 1; x.wf = 1; end
                end
                default: ;
            endcase
            apply(x, clr_first && (idx == 0));
            obs_rgb[idx]  = rgb;
            obs_cw[idx]   = collWall;
            obs_cg[idx]   = collGhost;
            obs_cd[idx]   = dotEaten;
            obs_fd[idx]   = frameDone;
            obs_hits[idx] = ghostHits;
            // Occasional off-raster coordinate: must never act as a frame end.
            if (m == M_RANDOM && $urandom_range(0, 5) == 0) begin
                y        = x;
                y.bright = ($urandom_range(0, 1) != 0);
                y.pf     = ($urandom_range(0, 1) != 0);
                y.gf     = ($urandom_range(0, 1) != 0);
                if ($urandom_range(0, 1) != 0) begin
                    y.h = TB_H + 10'd1 + 10'($urandom_range(0, 900));
                    y.v = TB_V;
                end else begin
                    y.h = TB_H;
                    y.v = TB_V + 10'd1 + 10'($urandom_range(0, 400));
                end
                apply(y, 1'b0);
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        hCount    = '0;
        vCount    = '0;
        bright    = 1'b0;
        wallRgb   = '0;
        pacRgb    = '0;
        ghostRgb  = '0;
        wallFill  = 1'b0;
        pacFill   = 1'b0;
        ghostFill = 1'b0;
        dotFill   = 1'b0;
        clearHits = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_rgb", 32'(rgb), 32'h0);
        check("reset_status", dut_status(), 32'h0);
        rst_n = 1'b1;

        // Release must not produce a frame pulse.
        run_frame(M_CLEAN);
        check("no_fd_on_release0", 32'(obs_fd[0]), 32'd0);
        check("no_fd_on_release1", 32'(obs_fd[1]), 32'd0);

        // Colour priority, two-clock latency.
        run_frame(M_PRIO);
        check("prio_ghost", 32'(obs_rgb[3]), 32'hF00);
        check("prio_pac", 32'(obs_rgb[4]), 32'h0F0);
        check("prio_blank", 32'(obs_rgb[5]), 32'h000);

        // Single wall overlap, then a clean frame.
        run_frame(M_WALL_ONE);
        run_frame(M_CLEAN);
        check("wall_set", 32'(obs_cw[0]), 32'd1);
        check("wall_no_ghost", 32'(obs_cg[0]), 32'd0);
        check("wall_fd_pulse", 32'(obs_fd[0]), 32'd1);
        check("wall_fd_single", 32'(obs_fd[1]), 32'd0);
        run_frame(M_CLEAN);
        check("wall_cleared", 32'(obs_cw[0]), 32'd0);

        // Overlap on the very last pixel belongs to the ending frame.
        run_frame(M_CORNER);
        run_frame(M_CLEAN);
        check("corner_counted", 32'(obs_cd[0]), 32'd1);
        run_frame(M_CLEAN);
        check("corner_not_next", 32'(obs_cd[0]), 32'd0);

        // Overlaps during blanking never count.
        run_frame(M_WALL_ONE);
        run_frame(M_BLANK);
        check("blank_prev_wall", 32'(obs_cw[0]), 32'd1);
        run_frame(M_CLEAN);
        check("blank_no_coll", 32'(obs_cw[0]), 32'd0);

        // Random frames against the model.
        repeat (12) run_frame(M_RANDOM);

        // Saturation of ghostHits and clear priority.
        run_frame(M_CLEAN, 1'b1);
        repeat (260) run_frame(M_GHOST_ONE);
        run_frame(M_GHOST_ONE);
        check("sat_hits", 32'(obs_hits[0]), 32'd255);
        check("sat_ghost", 32'(obs_cg[0]), 32'd1);
        run_frame(M_GHOST_ONE, 1'b1);
        check("clear_at_sat", 32'(obs_hits[0]), 32'd0);
        run_frame(M_CLEAN, 1'b1);
        check("clear_beats_inc", 32'(obs_hits[0]), 32'd0);
        check("clear_holds", 32'(obs_hits[1]), 32'd0);

        // Mid-frame reset discards the ghost overlap already seen.
        run_frame(M_GHOST_ONE);
        run_frame(M_GHOST_ONE, 1'b0, PIX / 2);
        check("pre_reset_ghost", 32'(obs_cg[0]), 32'd1);
        run_frame(M_CLEAN);
        check("post_reset_ghost", 32'(obs_cg[0]), 32'd0);
        check("post_reset_hits", 32'(obs_hits[0]), 32'd0);
        check("post_reset_fd", 32'(obs_fd[0]), 32'd1);

        repeat (3) run_frame(M_RANDOM);
        run_frame(M_CLEAN);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
